// File: rtl/decode_execute_register_if.sv
// Decode-to-execute boundary: decode-side fields, writeback bypass inputs,
// the registered execute-side fields and the stall/flush event counters.
interface decode_execute_register_if #(
    parameter int N = 32,
    parameter int C = 16
);
    // Pipeline control
    logic         StallE;
    logic         FlushE;

    // Decode-stage inputs
    logic         ValidD;
    logic [N-1:0] RD1D;
    logic [N-1:0] RD2D;
    logic [N-1:0] ExtImmD;
    logic [4:0]   RA1D;
    logic [4:0]   RA2D;
    logic [4:0]   WA3D;
    logic         RegWriteD;
    logic         MemWriteD;
    logic         MemtoRegD;
    logic         BranchD;
    logic         ALUSrcD;
    logic [3:0]   ALUControlD;

    // Writeback port, shared with the register file write side
    logic         RegWriteW;
    logic [4:0]   WA3W;
    logic [N-1:0] ResultW;

    // Execute-stage registered outputs
    logic         ValidE;
    logic [N-1:0] SrcAE;
    logic [N-1:0] SrcBE;
    logic [N-1:0] ExtImmE;
    logic [4:0]   RA1E;
    logic [4:0]   RA2E;
    logic [4:0]   WA3E;
    logic         RegWriteE;
    logic         MemWriteE;
    logic         MemtoRegE;
    logic         BranchE;
    logic         ALUSrcE;
    logic [3:0]   ALUControlE;

    // Performance counters
    logic [C-1:0] stall_count;
    logic [C-1:0] flush_count;

    modport master (
        output StallE, FlushE, ValidD, RD1D, RD2D, ExtImmD, RA1D, RA2D, WA3D,
               RegWriteD, MemWriteD, MemtoRegD, BranchD, ALUSrcD, ALUControlD,
               RegWriteW, WA3W, ResultW,
        input  ValidE, SrcAE, SrcBE, ExtImmE, RA1E, RA2E, WA3E,
               RegWriteE, MemWriteE, MemtoRegE, BranchE, ALUSrcE, ALUControlE,
               stall_count, flush_count
    );

    modport slave (
        input  StallE, FlushE, ValidD, RD1D, RD2D, ExtImmD, RA1D, RA2D, WA3D,
               RegWriteD, MemWriteD, MemtoRegD, BranchD, ALUSrcD, ALUControlD,
               RegWriteW, WA3W, ResultW,
        output ValidE, SrcAE, SrcBE, ExtImmE, RA1E, RA2E, WA3E,
               RegWriteE, MemWriteE, MemtoRegE, BranchE, ALUSrcE, ALUControlE,
               stall_count, flush_count
    );
endinterface

// File: rtl/decode_execute_register.sv
// Decode/execute pipeline register with writeback bypass on load, operand
// refresh while stalled, flush bubbles and saturating stall/flush counters.
module decode_execute_register #(
    parameter int N = 32,
    parameter int C = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    decode_execute_register_if.slave    bus
);

    localparam logic [C-1:0] CNT_MAX = '1;

    logic byp_a_d;
    logic byp_b_d;
    logic refresh_a;
    logic refresh_b;

    // Scalar, non-zero register being written this cycle: the register file
    // has not committed it yet, so the read data is stale.
    assign byp_a_d = bus.RegWriteW && (bus.WA3W == bus.RA1D)
                     && (bus.RA1D != 5'd0) && !bus.RA1D[4];
    assign byp_b_d = bus.RegWriteW && (bus.WA3W == bus.RA2D)
                     && (bus.RA2D != 5'd0) && !bus.RA2D[4];

    assign refresh_a = bus.ValidE && bus.RegWriteW && (bus.WA3W == bus.RA1E)
                       && (bus.RA1E != 5'd0) && !bus.RA1E[4];
    assign refresh_b = bus.ValidE && bus.RegWriteW && (bus.WA3W == bus.RA2E)
                       && (bus.RA2E != 5'd0) && !bus.RA2E[4];

    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.ValidE      <= 1'b0;
            bus.SrcAE       <= '0;
            bus.SrcBE       <= '0;
            bus.ExtImmE     <= '0;
            bus.RA1E        <= '0;
            bus.RA2E        <= '0;
            bus.WA3E        <= '0;
            bus.RegWriteE   <= 1'b0;
            bus.MemWriteE   <= 1'b0;
            bus.MemtoRegE   <= 1'b0;
            bus.BranchE     <= 1'b0;
            bus.ALUSrcE     <= 1'b0;
            bus.ALUControlE <= '0;
            bus.stall_count <= '0;
            bus.flush_count <= '0;
        end else if (bus.FlushE) begin
            bus.ValidE      <= 1'b0;
            bus.SrcAE       <= '0;
            bus.SrcBE       <= '0;
            bus.ExtImmE     <= '0;
            bus.RA1E        <= '0;
            bus.RA2E        <= '0;
            bus.WA3E        <= '0;
            bus.RegWriteE   <= 1'b0;
            bus.MemWriteE   <= 1'b0;
            bus.MemtoRegE   <= 1'b0;
            bus.BranchE     <= 1'b0;
            bus.ALUSrcE     <= 1'b0;
            bus.ALUControlE <= '0;
            if (bus.flush_count != CNT_MAX) bus.flush_count <= bus.flush_count + 1'b1;
        end else if (bus.StallE) begin
            // Held operands track writebacks that retire during the stall.
            if (refresh_a) bus.SrcAE <= bus.ResultW;
            if (refresh_b) bus.SrcBE <= bus.ResultW;
            if (bus.stall_count != CNT_MAX) bus.stall_count <= bus.stall_count + 1'b1;
        end else begin
            bus.ValidE      <= bus.ValidD;
            bus.SrcAE       <= byp_a_d ? bus.ResultW : bus.RD1D;
            bus.SrcBE       <= byp_b_d ? bus.ResultW : bus.RD2D;
            bus.ExtImmE     <= bus.ExtImmD;
            bus.RA1E        <= bus.RA1D;
            bus.RA2E        <= bus.RA2D;
            bus.WA3E        <= bus.WA3D;
            bus.RegWriteE   <= bus.RegWriteD;
            bus.MemWriteE   <= bus.MemWriteD;
            bus.MemtoRegE   <= bus.MemtoRegD;
            bus.BranchE     <= bus.BranchD;
            bus.ALUSrcE     <= bus.ALUSrcD;
            bus.ALUControlE <= bus.ALUControlD;
        end
    end

endmodule

// File: tb/tb_decode_execute_register.sv
// Bench for decode_execute_register: directed scenarios plus random traffic,
// each cycle's expected E state queued by a reference model and checked by a monitor.
module tb_decode_execute_register;

    localparam int N = 32;
    localparam int C = 4;

    typedef struct packed {
        logic         valid;
        logic [N-1:0] srca;
        logic [N-1:0] srcb;
        logic [N-1:0] imm;
        logic [4:0]   ra1;
        logic [4:0]   ra2;
        logic [4:0]   wa3;
        logic         regwrite;
        logic         memwrite;
        logic         memtoreg;
        logic         branch;
        logic         alusrc;
        logic [3:0]   aluctl;
        logic [C-1:0] stall_cnt;
        logic [C-1:0] flush_cnt;
    } e_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    e_t   model;
    e_t   exp_q[$];

    always #5 clk = ~clk;

    decode_execute_register_if #(.N(N), .C(C)) bus ();

    decode_execute_register #(.N(N), .C(C)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
        end
    endtask

    // A register read is stale when a scalar, non-zero register is being written.
    function automatic logic forwarded(input logic [4:0] ra);
        return bus.RegWriteW && (ra == bus.WA3W) && (ra != 5'd0) && (ra < 5'd16);
    endfunction

    function automatic logic [C-1:0] bump(input logic [C-1:0] v);
        int unsigned top;
        top = (1 << C) - 1;
        return (int'(v) >= top) ? v : C'(int'(v) + 1);
    endfunction

    function automatic e_t model_next(input e_t cur);
        e_t n;
        n = cur;
        if (!rst) begin
            n = '0;
        end else if (bus.FlushE) begin
            n = '0;
            n.stall_cnt = cur.stall_cnt;
            n.flush_cnt = bump(cur.flush_cnt);
        end else if (bus.StallE) begin
            if (cur.valid && forwarded(cur.ra1)) n.srca = bus.ResultW;
            if (cur.valid && forwarded(cur.ra2)) n.srcb = bus.ResultW;
            n.stall_cnt = bump(cur.stall_cnt);
        end else begin
            n.valid    = bus.ValidD;
            n.srca     = forwarded(bus.RA1D) ? bus.ResultW : bus.RD1D;
            n.srcb     = forwarded(bus.RA2D) ? bus.ResultW : bus.RD2D;
            n.imm      = bus.ExtImmD;
            n.ra1      = bus.RA1D;
            n.ra2      = bus.RA2D;
            n.wa3      = bus.WA3D;
            n.regwrite = bus.RegWriteD;
            n.memwrite = bus.MemWriteD;
            n.memtoreg = bus.MemtoRegD;
            n.branch   = bus.BranchD;
            n.alusrc   = bus.ALUSrcD;
            n.aluctl   = bus.ALUControlD;
        end
        return n;
    endfunction

    // Driver: queue the state expected after the coming edge, then cross it.
    task automatic step();
        model = model_next(model);
        exp_q.push_back(model);
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        rst             = 1'b1;
        bus.StallE      = 1'b0;
        bus.FlushE      = 1'b0;
        bus.ValidD      = 1'b0;
        bus.RD1D        = '0;
        bus.RD2D        = '0;
        bus.ExtImmD     = '0;
        bus.RA1D        = '0;
        bus.RA2D        = '0;
        bus.WA3D        = '0;
        bus.RegWriteD   = 1'b0;
        bus.MemWriteD   = 1'b0;
        bus.MemtoRegD   = 1'b0;
        bus.BranchD     = 1'b0;
        bus.ALUSrcD     = 1'b0;
        bus.ALUControlD = '0;
        bus.RegWriteW   = 1'b0;
        bus.WA3W        = '0;
        bus.ResultW     = '0;
    endtask

    function automatic logic [4:0] pick_addr();
        case ($urandom_range(0, 3))
            0:       return 5'd0;
            1:       return 5'($urandom_range(1, 3));
            2:       return 5'(16 + $urandom_range(0, 3));
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    task automatic random_inputs();
        rst             = ($urandom_range(0, 49) != 0);
        bus.StallE      = ($urandom_range(0, 3) == 0);
        bus.FlushE      = ($urandom_range(0, 9) == 0);
        bus.ValidD      = ($urandom_range(0, 4) != 0);
        bus.RD1D        = $urandom;
        bus.RD2D        = $urandom;
        bus.ExtImmD     = $urandom;
        bus.RA1D        = pick_addr();
        bus.RA2D        = pick_addr();
        bus.WA3D        = 5'($urandom_range(0, 31));
        bus.RegWriteD   = 1'($urandom_range(0, 1));
        bus.MemWriteD   = 1'($urandom_range(0, 1));
        bus.MemtoRegD   = 1'($urandom_range(0, 1));
        bus.BranchD     = 1'($urandom_range(0, 1));
        bus.ALUSrcD     = 1'($urandom_range(0, 1));
        bus.ALUControlD = 4'($urandom_range(0, 15));
        bus.RegWriteW   = ($urandom_range(0, 2) != 0);
        bus.WA3W        = pick_addr();
        bus.ResultW     = $urandom;
    endtask

    // Monitor: E outputs are registered, so every edge presents a new state.
    always @(posedge clk) begin
        e_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("ValidE",      N'(bus.ValidE),      N'(e.valid));
            chk("SrcAE",       bus.SrcAE,           e.srca);
            chk("SrcBE",       bus.SrcBE,           e.srcb);
            chk("ExtImmE",     bus.ExtImmE,         e.imm);
            chk("RA1E",        N'(bus.RA1E),        N'(e.ra1));
            chk("RA2E",        N'(bus.RA2E),        N'(e.ra2));
            chk("WA3E",        N'(bus.WA3E),        N'(e.wa3));
            chk("RegWriteE",   N'(bus.RegWriteE),   N'(e.regwrite));
            chk("MemWriteE",   N'(bus.MemWriteE),   N'(e.memwrite));
            chk("MemtoRegE",   N'(bus.MemtoRegE),   N'(e.memtoreg));
            chk("BranchE",     N'(bus.BranchE),     N'(e.branch));
            chk("ALUSrcE",     N'(bus.ALUSrcE),     N'(e.alusrc));
            chk("ALUControlE", N'(bus.ALUControlE), N'(e.aluctl));
            chk("stall_count", N'(bus.stall_count), N'(e.stall_cnt));
            chk("flush_count", N'(bus.flush_count), N'(e.flush_cnt));
        end
    end

    initial begin
        model = '0;
        idle_inputs();

        // Reset with busy inputs, including a stall request it must override
        rst = 1'b0;
        bus.ValidD = 1'b1; bus.RD1D = 32'hDEAD_BEEF; bus.RD2D = 32'hCAFE_F00D;
        bus.ExtImmD = 32'h0000_0ABC; bus.RA1D = 5'd3; bus.RA2D = 5'd4; bus.WA3D = 5'd9;
        bus.RegWriteD = 1'b1; bus.MemWriteD = 1'b1; bus.ALUControlD = 4'hF;
        bus.StallE = 1'b1;
        step(); step();
        chk("reset_ValidE", N'(bus.ValidE), '0);
        chk("reset_SrcAE", bus.SrcAE, '0);
        chk("reset_stall_count", N'(bus.stall_count), '0);

        idle_inputs();
        bus.ValidD = 1'b1; bus.RD1D = 32'h1234; bus.RA1D = 5'd1;
        step();
        chk("first_load_SrcAE", bus.SrcAE, 32'h1234);
        chk("first_load_ValidE", N'(bus.ValidE), 1);

        // Load-time bypass: scalar hit, register zero, vector address
        bus.RA1D = 5'd5; bus.RD1D = 32'hAAAA;
        bus.RegWriteW = 1'b1; bus.WA3W = 5'd5; bus.ResultW = 32'h5555;
        step();
        chk("bypass_hit_SrcAE", bus.SrcAE, 32'h5555);
        bus.RA1D = 5'd0; bus.WA3W = 5'd0;
        step();
        chk("bypass_r0_SrcAE", bus.SrcAE, 32'hAAAA);
        bus.RA2D = 5'h13; bus.WA3W = 5'h13; bus.RD2D = 32'hFFFF_FFFF;
        step();
        chk("bypass_vector_SrcBE", bus.SrcBE, 32'hFFFF_FFFF);

        // Stall refresh of a held operand
        idle_inputs();
        bus.ValidD = 1'b1; bus.RA1D = 5'd7; bus.RD1D = 32'h77; bus.RA2D = 5'd6; bus.RD2D = 32'h1;
        step();
        bus.StallE = 1'b1; bus.RD1D = 32'h9999; bus.RD2D = 32'h8888; bus.RA2D = 5'd2;
        step();
        bus.RegWriteW = 1'b1; bus.WA3W = 5'd6; bus.ResultW = 32'hBEEF;
        step();
        bus.RegWriteW = 1'b0;
        step();
        chk("stall_refresh_SrcBE", bus.SrcBE, 32'hBEEF);
        chk("stall_hold_SrcAE", bus.SrcAE, 32'h77);
        chk("stall_hold_RA2E", N'(bus.RA2E), 6);
        chk("stall_count_3", N'(bus.stall_count), 3);

        // Flush wins over stall and over a pending refresh
        idle_inputs();
        bus.ValidD = 1'b1; bus.RegWriteD = 1'b1; bus.RA1D = 5'd2; bus.RD1D = 32'h42;
        step();
        bus.StallE = 1'b1; bus.FlushE = 1'b1;
        bus.RegWriteW = 1'b1; bus.WA3W = 5'd2; bus.ResultW = 32'h1111;
        step();
        chk("flush_ValidE", N'(bus.ValidE), 0);
        chk("flush_RegWriteE", N'(bus.RegWriteE), 0);
        chk("flush_SrcAE", bus.SrcAE, 0);
        chk("flush_count_1", N'(bus.flush_count), 1);
        chk("flush_stall_count", N'(bus.stall_count), 3);

        // Stall counter saturation
        idle_inputs();
        bus.StallE = 1'b1;
        for (int i = 0; i < 20; i++) step();
        chk("stall_saturate", N'(bus.stall_count), 15);

        // Reset during a stall, then stall straight out of reset
        idle_inputs();
        bus.ValidD = 1'b1; bus.RD1D = 32'h5A5A; bus.RA1D = 5'd1;
        step();
        bus.StallE = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("midreset_ValidE", N'(bus.ValidE), 0);
        chk("midreset_SrcAE", bus.SrcAE, 0);
        rst = 1'b1;
        step();
        chk("post_reset_SrcAE", bus.SrcAE, 0);
        chk("post_reset_stall_count", N'(bus.stall_count), 1);

        // Random traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            random_inputs();
            step();
        end

        idle_inputs();
        @(posedge clk);
        #3;
        if (exp_q.size() != 0) chk("queue_drained", N'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
